// File: rtl/pwm_gen_multi_pkg.sv
// pwm_gen_multi_pkg: carrier direction and deadtime state encodings plus default widths
// shared by pwm_gen_multi and pwm_deadtime.
package pwm_gen_multi_pkg;
    localparam int DEF_N_CH = 3;
    localparam int DEF_CW   = 8;
    localparam int DEF_DT_W = 6;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
    typedef enum logic [1:0] {IDLE_LO = 2'd0, DT_WAIT = 2'd1, ON_HI = 2'd2, ON_LO = 2'd3} dt_state_t;
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: one gate-leg deadtime inserter; both sides stay off until raw has been
// stable for dt sys_ce cycles, so a raw pulse shorter than dt is swallowed.
module pwm_deadtime
    import pwm_gen_multi_pkg::*;
#(
    parameter int DT_W = DEF_DT_W
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            sys_ce,
    input  logic            en,
    input  logic            raw,
    input  logic [DT_W-1:0] dt,
    output logic            so_hi,
    output logic            so_lo
);
    dt_state_t state, state_nx;
    logic prev;
    logic [DT_W-1:0] cnt, run_len;

    // run_len: cycles raw held its current value before this one, saturating
    always_comb begin
        run_len = raw != prev ? '0 : &cnt ? cnt : cnt + DT_W'(1);
        state_nx = !en ? IDLE_LO : run_len < dt ? DT_WAIT : raw ? ON_HI : ON_LO;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE_LO;
            prev  <= 1'b0;
            cnt   <= '0;
        end else if (sys_ce) begin
            state <= state_nx;
            prev  <= raw;
            cnt   <= run_len;
        end
    end

    assign so_hi = state == ON_HI;
    assign so_lo = state == ON_LO;
endmodule

// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: N_CH-channel triangle-carrier PWM with prescaler and valley-shadowed duties.
// Define PWM_DEADTIME_EN to add the dt port and per-channel pwm_deadtime insertion.
module pwm_gen_multi
    import pwm_gen_multi_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
`ifdef PWM_DEADTIME_EN
    parameter int DT_W = DEF_DT_W,
`endif
    parameter int CW   = DEF_CW
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                sys_ce,
    input  logic                enable,
    input  logic [7:0]          divider,
    input  logic [CW-1:0]       carrier_max,
    input  logic [N_CH*CW-1:0]  duty,
    input  logic                duty_wr,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]     dt,
`endif
    output logic [CW-1:0]       carrier,
    output logic                valley,
    output logic                peak,
    output logic [N_CH-1:0]     so_hi,
    output logic [N_CH-1:0]     so_lo
);
    logic run, run_q, start, tick, valley_ev, peak_ev, pend_flag;
    logic [7:0] pcnt;
    logic [CW-1:0] carrier_nx, a;
    dir_t dir, dir_nx;
    logic [N_CH*CW-1:0] pending, active;
    logic [N_CH-1:0] raw, raw_nx;

    assign run       = enable && carrier_max >= CW'(2);
    // first running cycle is treated as a valley so a restart picks up pending duties
    assign start     = run && !run_q;
    assign tick      = run && run_q && pcnt >= divider;
    assign valley_ev = start || (tick && carrier_nx == '0);
    assign peak_ev   = tick && carrier_nx == carrier_max;

    always_comb begin
        a = '0;
        raw_nx = '0;
        carrier_nx = carrier >= carrier_max ? carrier - CW'(1)
                   : (dir == DIR_UP || carrier == '0) ? carrier + CW'(1) : carrier - CW'(1);
        dir_nx = carrier_nx == carrier_max ? DIR_DOWN
               : carrier_nx == '0 ? DIR_UP
               : carrier >= carrier_max ? DIR_DOWN : dir;
        for (int k = 0; k < N_CH; k++) begin
            a = active[k*CW +: CW];
            raw_nx[k] = run && a != '0 && (a >= carrier_max || carrier < a);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            run_q     <= 1'b0;
            pcnt      <= '0;
            carrier   <= '0;
            dir       <= DIR_UP;
            pending   <= '0;
            active    <= '0;
            pend_flag <= 1'b0;
            raw       <= '0;
            valley    <= 1'b0;
            peak      <= 1'b0;
        end else begin
            valley <= sys_ce && valley_ev;
            peak   <= sys_ce && peak_ev;
            if (sys_ce) begin
                run_q <= run;
                raw   <= raw_nx;
                if (duty_wr) pending <= duty;
                // a write on the valley cycle stays pending while the old pending goes live
                pend_flag <= duty_wr || (pend_flag && !valley_ev);
                if (valley_ev && pend_flag) active <= pending;
                if (!run) begin
                    pcnt    <= '0;
                    carrier <= '0;
                    dir     <= DIR_UP;
                end else if (tick) begin
                    pcnt    <= '0;
                    carrier <= carrier_nx;
                    dir     <= dir_nx;
                end else if (run_q) begin
                    pcnt <= pcnt + 8'd1;
                end
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    for (genvar g = 0; g < N_CH; g++) begin : g_dt
        pwm_deadtime #(.DT_W(DT_W)) u_dt (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .sys_ce    (sys_ce),
            .en        (run),
            .raw       (raw[g]),
            .dt        (dt),
            .so_hi     (so_hi[g]),
            .so_lo     (so_lo[g])
        );
    end
`else
    assign so_hi = raw;
    assign so_lo = ~raw & {N_CH{run_q}};
`endif
endmodule

// File: tb/tb_pwm_gen_multi.sv
// tb_pwm_gen_multi: randomized self-checking bench; the reference derives the carrier
// from a triangle function of elapsed ticks since the last restart.
module tb_pwm_gen_multi;
    logic clk = 0, rst_n = 0, ce = 1, enable = 0, duty_wr = 0;
    logic [7:0] divider = 0, cmax = 10;
    logic [23:0] duty = 0;
`ifdef PWM_DEADTIME_EN
    logic [5:0] dt = 0;
`endif
    logic [7:0] carrier;
    logic valley, peak;
    logic [2:0] so_hi, so_lo;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pwm_gen_multi dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .sys_ce(ce), .enable(enable),
        .divider(divider), .carrier_max(cmax), .duty(duty), .duty_wr(duty_wr),
`ifdef PWM_DEADTIME_EN
        .dt(dt),
`endif
        .carrier(carrier), .valley(valley), .peak(peak), .so_hi(so_hi), .so_lo(so_lo)
    );

    int m_c, e_car;
    int m_act[3], m_pend[3], dlen[3];
    logic m_started, m_flag, e_val, e_pk;
    logic [2:0] m_raw, e_hi, e_lo, dprev;

    always @(posedge clk) begin
        logic run, vnow;
        logic [2:0] nraw;
        int j, m;
        if (!rst_n) begin
            m_started = 0; m_c = 0; m_flag = 0; e_car = 0; e_val = 0; e_pk = 0;
            m_raw = 0; e_hi = 0; e_lo = 0; dprev = 0;
            for (int k = 0; k < 3; k++) begin m_act[k] = 0; m_pend[k] = 0; dlen[k] = 0; end
        end else begin
            e_val = 0; e_pk = 0;
            if (ce) begin
                m = int'(cmax);
                run = enable && m >= 2;
                vnow = 0;
                for (int k = 0; k < 3; k++)
                    nraw[k] = run && m_act[k] != 0 && (m_act[k] >= m || e_car < m_act[k]);
                if (!run) begin
                    m_started = 0; e_car = 0;
                end else if (!m_started) begin
                    m_started = 1; m_c = 0; vnow = 1;
                end else begin
                    m_c++;
                    if (m_c % (int'(divider) + 1) == 0) begin
                        j = (m_c / (int'(divider) + 1)) % (2 * m);
                        e_car = j <= m ? j : 2 * m - j;
                        vnow = j == 0;
                        e_pk = j == m;
                    end
                end
                e_val = vnow;
                if (vnow && m_flag) begin
                    for (int k = 0; k < 3; k++) m_act[k] = m_pend[k];
                    m_flag = 0;
                end
                if (duty_wr) begin
                    for (int k = 0; k < 3; k++) m_pend[k] = int'(duty[k*8 +: 8]);
                    m_flag = 1;
                end
`ifdef PWM_DEADTIME_EN
                for (int k = 0; k < 3; k++) begin
                    if (m_raw[k] != dprev[k]) dlen[k] = 0;
                    else if (dlen[k] < 63) dlen[k]++;
                    dprev[k] = m_raw[k];
                    e_hi[k] = run && dlen[k] >= int'(dt) && m_raw[k];
                    e_lo[k] = run && dlen[k] >= int'(dt) && !m_raw[k];
                end
                m_raw = nraw;
`else
                m_raw = nraw;
                e_hi = m_raw;
                e_lo = ~m_raw & {3{m_started}};
`endif
            end
        end
    end

    wire [15:0] obs  = {carrier, valley, peak, so_hi, so_lo};
    wire [15:0] expv = {e_car[7:0], e_val, e_pk, e_hi, e_lo};

    always @(negedge clk)
        if ((so_hi & so_lo) != 3'b000) begin
            errors++;
            $display("FAIL overlap so_hi=%b so_lo=%b required disjoint", so_hi, so_lo);
        end

    task automatic setup(input logic [7:0] div, input logic [7:0] mx, input logic [23:0] d);
        enable = 0;
        @(negedge clk);
        divider = div; cmax = mx; duty = d; duty_wr = 1;
        @(negedge clk);
        duty_wr = 0; enable = 1;
    endtask

    task automatic test_reset;
        rst_n = 0; ce = 1; enable = 1; duty = '1; duty_wr = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 16'h0000) begin errors++; $display("FAIL reset obs=%h required 0000", obs); end
        duty_wr = 0; duty = 0; enable = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_idle obs=%h required %h", obs, expv); end
    endtask

    task automatic test_basic;
        int h = 0;
        setup(0, 10, {8'd10, 8'd0, 8'd5});
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL basic cyc=%0d obs=%h required %h", i, obs, expv); end
            if (i >= 20 && i < 40) h += int'(so_hi[0]);
        end
        checks++;
        if (h !== 9) begin errors++; $display("FAIL basic_highs got=%0d required 9", h); end
    endtask

    task automatic test_extremes;
        setup(0, 10, {8'd200, 8'd10, 8'd0});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL extremes cyc=%0d obs=%h required %h", i, obs, expv); end
            if (i >= 2) begin
                checks++;
                if ({so_hi, so_lo} !== 6'b110_001)
                    begin errors++; $display("FAIL extremes_fixed hi=%b lo=%b required 110/001", so_hi, so_lo); end
            end
        end
    endtask

    task automatic test_shadow;
        int h, n;
        logic [7:0] pc;
        setup(0, 10, {16'd0, 8'd5});
        for (int i = 0; i < 5; i++) @(negedge clk);
        duty = {16'd0, 8'd7}; duty_wr = 1;
        @(negedge clk);
        duty_wr = 0;
        for (n = 0; n < 40 && carrier != 8'd6; n++) @(negedge clk);
        checks++;
        if (n == 40 || so_hi[0] !== 1'b0) begin errors++; $display("FAIL shadow_hold n=%0d hi0=%b required 0", n, so_hi[0]); end
        for (n = 0; n < 40 && !valley; n++) @(negedge clk);
        h = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL shadow cyc=%0d obs=%h required %h", i, obs, expv); end
            h += int'(so_hi[0]);
        end
        checks++;
        if (h !== 13) begin errors++; $display("FAIL shadow_d7 highs=%0d required 13", h); end
        repeat (4) @(negedge clk);
        duty = {16'd0, 8'd9}; duty_wr = 1;
        @(negedge clk);
        duty_wr = 0;
        pc = carrier;
        for (n = 0; n < 40 && !(carrier == 8'd1 && pc == 8'd2); n++) begin pc = carrier; @(negedge clk); end
        duty = {16'd0, 8'd3}; duty_wr = 1;
        @(negedge clk);
        duty_wr = 0;
        checks++;
        if (n == 40 || valley !== 1'b1) begin errors++; $display("FAIL shadow_valley_wr n=%0d valley=%b required 1", n, valley); end
        for (int w = 0; w < 2; w++) begin
            h = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL shadow2 cyc=%0d obs=%h required %h", i, obs, expv); end
                h += int'(so_hi[0]);
            end
            checks++;
            if (h !== (w == 0 ? 17 : 5)) begin errors++; $display("FAIL shadow_win%0d highs=%0d required %0d", w, h, w == 0 ? 17 : 5); end
        end
    endtask

    task automatic test_prescaler;
        int lasti, nchg;
        logic [7:0] lastc;
        for (int p = 0; p < 2; p++) begin
            ce = 1;
            setup(3, 10, {8'd5, 8'd5, 8'd5});
            lasti = 0; nchg = 0; lastc = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL prescale%0d cyc=%0d obs=%h required %h", p, i, obs, expv); end
                if (carrier != lastc) begin
                    if (nchg > 1) begin
                        checks++;
                        if (i - lasti !== (p == 0 ? 4 : 8))
                            begin errors++; $display("FAIL prescale_step%0d gap=%0d required %0d", p, i - lasti, p == 0 ? 4 : 8); end
                    end
                    lasti = i; lastc = carrier; nchg++;
                end
                if (p == 1) ce = ~ce;
            end
        end
        ce = 1;
    endtask

    task automatic test_enable;
        int n;
        setup(0, 10, {8'd0, 8'd0, 8'd7});
        for (n = 0; n < 100 && carrier != 8'd6; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL enable_run obs=%h required %h", obs, expv); end
        end
        enable = 0;
        @(negedge clk);
        checks++;
        if (n == 100 || carrier !== 8'd0 || so_hi !== 3'b0 || so_lo !== 3'b0)
            begin errors++; $display("FAIL enable_off n=%0d car=%0d hi=%b lo=%b required 0", n, carrier, so_hi, so_lo); end
        enable = 1;
        @(negedge clk);
        checks++;
        if (valley !== 1'b1 || obs !== expv) begin errors++; $display("FAIL enable_restart obs=%h required %h valley=1", obs, expv); end
        repeat (7) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (obs !== 16'h0000) begin errors++; $display("FAIL midreset obs=%h required 0000", obs); end
        rst_n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv || so_hi !== 3'b0) begin errors++; $display("FAIL postreset cyc=%0d obs=%h required %h", i, obs, expv); end
        end
    endtask

    task automatic test_small_max;
        setup(0, 1, {8'd1, 8'd1, 8'd1});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 16'h0000) begin errors++; $display("FAIL max1 cyc=%0d obs=%h required 0000", i, obs); end
        end
        setup(0, 2, {8'd2, 8'd1, 8'd0});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL max2 cyc=%0d obs=%h required %h", i, obs, expv); end
        end
    endtask

`ifdef PWM_DEADTIME_EN
    task automatic test_deadtime;
        int g = 0, prevon = 0, cur;
        dt = 4;
        setup(0, 10, {8'd10, 8'd2, 8'd5});
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv || so_hi[1] !== 1'b0) begin errors++; $display("FAIL deadtime cyc=%0d obs=%h required %h", i, obs, expv); end
            cur = so_hi[0] ? 1 : so_lo[0] ? 2 : 0;
            if (cur == 0) g++;
            else begin
                if (prevon != 0 && cur != prevon) begin
                    checks++;
                    if (g !== 4) begin errors++; $display("FAIL deadtime_gap got=%0d required 4", g); end
                end
                g = 0; prevon = cur;
            end
        end
    endtask
`endif

    task automatic test_random;
        for (int s = 0; s < 6; s++) begin
`ifdef PWM_DEADTIME_EN
            dt = 6'($urandom_range(0, 6));
`endif
            ce = 1;
            setup(8'($urandom_range(0, 3)), 8'($urandom_range(2, 20)), 24'($urandom));
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL random seg=%0d cyc=%0d obs=%h required %h", s, i, obs, expv); end
                ce = $urandom_range(0, 3) != 0;
                duty_wr = $urandom_range(0, 9) == 0;
                duty = 24'($urandom);
            end
            duty_wr = 0;
        end
        ce = 1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_shadow;
        test_prescaler;
        test_enable;
        test_small_max;
`ifdef PWM_DEADTIME_EN
        test_deadtime;
`endif
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
